// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small transmit FIFO.
// Frame format is set by parameters: 5..9 data bits sent LSB first, optional
// odd/even parity, 1 or 2 stop bits. Queued words go out back to back with no
// idle bit time between frames.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 27,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                                i_Clock,
    input  logic                                i_Rst_L,
    input  logic                                i_Tx_DV,
    input  logic [DATA_BITS-1:0]                i_Tx_Byte,
    output logic                                o_Tx_Ready,
    output logic                                o_Tx_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_Fifo_Count,
    output logic                                o_Tx_Active,
    output logic                                o_Tx_Serial,
    output logic                                o_Tx_Done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CLK_W = $clog2(CLKS_PER_BIT * 2);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] STOP_LAST = CLK_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    // Reject parameter sets the datapath is not built for.
    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY_MODE < 0 || PARITY_MODE > 2 ||
            !(STOP_BITS == 1 || STOP_BITS == 2) ||
            FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("uart_tx_fifo: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit to append: odd mode makes the total ones count odd,
    // even mode makes it even (plain XOR of the data bits).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
        if (PARITY_MODE == 1) begin
            return ~(^word);
        end
        return ^word;
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    // Transmit FSM state
    state_t               state;
    logic [CLK_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    assign fifo_full    = (fifo_cnt == FULL_CNT);
    assign fifo_empty   = (fifo_cnt == '0);
    assign push         = i_Tx_DV && !fifo_full;
    assign o_Tx_Ready   = !fifo_full;
    assign o_Fifo_Count = fifo_cnt;

    // Pop the head word whenever the FSM is ready to start a new frame:
    // from IDLE, or on the last stop cycle so the next start bit follows directly.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE) begin
                pop = 1'b1;
            end else if (state == S_STOP && clk_cnt == STOP_LAST) begin
                pop = 1'b1;
            end
        end
    end

    // Write accepted words into the FIFO storage.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_Tx_Byte;
        end
    end

    // FIFO pointers, occupancy and the dropped-push pulse.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            o_Tx_Overflow <= 1'b0;
        end else begin
            // A push while full is dropped even if a pop frees a slot this cycle.
            o_Tx_Overflow <= i_Tx_DV && fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Capture the popped word and its parity; shift data out LSB first.
    always_ff @(posedge i_Clock) begin
        if (pop) begin
            tx_shift <= fifo_mem[rd_ptr];
            tx_par   <= parity_bit(fifo_mem[rd_ptr]);
        end else if (state == S_DATA && clk_cnt == BIT_LAST) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    // Frame sequencer: drives the registered line, active flag and done pulse.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    if (pop) begin
                        state       <= S_START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt     <= '0;
                        bit_idx     <= '0;
                        state       <= S_DATA;
                        o_Tx_Serial <= tx_shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end

                S_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            if (PARITY_MODE != 0) begin
                                state       <= S_PARITY;
                                o_Tx_Serial <= tx_par;
                            end else begin
                                state       <= S_STOP;
                                o_Tx_Serial <= 1'b1;
                            end
                        end else begin
                            bit_idx     <= bit_idx + IDX_W'(1);
                            // tx_shift shifts on this same edge, so bit 1 is the next bit out.
                            o_Tx_Serial <= tx_shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end

                S_PARITY: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt     <= '0;
                        state       <= S_STOP;
                        o_Tx_Serial <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end

                S_STOP: begin
                    if (clk_cnt == STOP_LAST) begin
                        clk_cnt   <= '0;
                        o_Tx_Done <= 1'b1;
                        if (pop) begin
                            // Next queued word: straight into its start bit.
                            state       <= S_START;
                            o_Tx_Serial <= 1'b0;
                            o_Tx_Active <= 1'b1;
                        end else begin
                            state       <= S_IDLE;
                            o_Tx_Serial <= 1'b1;
                            o_Tx_Active <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    clk_cnt     <= '0;
                    bit_idx     <= '0;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitter instances (8N1, 8E1, 8O1, 7N2, all at
// 4 clocks per bit). Stimulus queues the expected line pattern of each frame
// (bit k of the entry = line level during bit time k); a per-instance monitor
// decodes frames off the serial line and compares them against the queue.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic [3:0] rst_n;
    logic [3:0] tx_dv;
    logic [7:0] b0, b1, b2;
    logic [6:0] b3;

    wire  [3:0] rdy, ovf, act, ser, dn;
    wire  [2:0] cnt0, cnt1, cnt2, cnt3;

    logic [15:0] exp_q [4][$];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .i_Clock(clk), .i_Rst_L(rst_n[0]), .i_Tx_DV(tx_dv[0]), .i_Tx_Byte(b0),
        .o_Tx_Ready(rdy[0]), .o_Tx_Overflow(ovf[0]), .o_Fifo_Count(cnt0),
        .o_Tx_Active(act[0]), .o_Tx_Serial(ser[0]), .o_Tx_Done(dn[0]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .i_Clock(clk), .i_Rst_L(rst_n[1]), .i_Tx_DV(tx_dv[1]), .i_Tx_Byte(b1),
        .o_Tx_Ready(rdy[1]), .o_Tx_Overflow(ovf[1]), .o_Fifo_Count(cnt1),
        .o_Tx_Active(act[1]), .o_Tx_Serial(ser[1]), .o_Tx_Done(dn[1]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .i_Clock(clk), .i_Rst_L(rst_n[2]), .i_Tx_DV(tx_dv[2]), .i_Tx_Byte(b2),
        .o_Tx_Ready(rdy[2]), .o_Tx_Overflow(ovf[2]), .o_Fifo_Count(cnt2),
        .o_Tx_Active(act[2]), .o_Tx_Serial(ser[2]), .o_Tx_Done(dn[2]));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .i_Clock(clk), .i_Rst_L(rst_n[3]), .i_Tx_DV(tx_dv[3]), .i_Tx_Byte(b3),
        .o_Tx_Ready(rdy[3]), .o_Tx_Overflow(ovf[3]), .o_Fifo_Count(cnt3),
        .o_Tx_Active(act[3]), .o_Tx_Serial(ser[3]), .o_Tx_Done(dn[3]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n;
        n = 0;
        while ((exp_q[g].size() != 0 || act[g] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout_u%0d: %0d frames still pending after %0d cycles", g, exp_q[g].size(), budget);
        end
        repeat (2) @(negedge clk);
    endtask

    // Frame monitors: one per instance, sampling on the falling edge.
    for (genvar g = 0; g < 4; g++) begin : g_mon
        localparam int NB = (g == 1 || g == 2) ? 11 : 10;
        localparam int L  = CPB * NB;
        initial begin : mon
            logic [15:0] bits;
            logic [15:0] want;
            bit          stable;
            bit          ctl_ok;
            bit          aborted;
            bit          more;
            forever begin
                @(negedge clk);
                if (rst_n[g] === 1'b1 && ser[g] === 1'b0) begin
                    more = 1'b1;
                    while (more) begin
                        bits    = '0;
                        stable  = 1'b1;
                        ctl_ok  = 1'b1;
                        aborted = 1'b0;
                        more    = 1'b0;
                        for (int k = 0; k < L; k++) begin
                            if (k != 0) @(negedge clk);
                            if (rst_n[g] !== 1'b1) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (k % CPB == 0) bits[k / CPB] = ser[g];
                            else if (ser[g] !== bits[k / CPB]) stable = 1'b0;
                            if (act[g] !== 1'b1) ctl_ok = 1'b0;
                            if (k != 0 && dn[g] !== 1'b0) ctl_ok = 1'b0;
                        end
                        if (!aborted) begin
                            @(negedge clk);
                            if (rst_n[g] !== 1'b1) aborted = 1'b1;
                        end
                        if (!aborted) begin
                            if (exp_q[g].size() == 0) begin
                                n_vec++;
                                n_bad++;
                                $display("FAIL unexpected_frame_u%0d: got 0x%0h, want no frame", g, bits);
                            end else begin
                                want = exp_q[g].pop_front();
                                chk($sformatf("frame_bits_u%0d", g), {16'h0, bits}, {16'h0, want});
                            end
                            chk($sformatf("bit_stable_u%0d", g), {31'h0, stable}, 32'h1);
                            chk($sformatf("active_no_early_done_u%0d", g), {31'h0, ctl_ok}, 32'h1);
                            chk($sformatf("done_at_frame_end_u%0d", g), {31'h0, dn[g]}, 32'h1);
                            more = (ser[g] === 1'b0 && rst_n[g] === 1'b1);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [7:0]  w3 [3]  = '{8'h00, 8'hFF, 8'h3C};
        logic [15:0] e3 [3]  = '{16'h200, 16'h3FE, 16'h278};
        logic [7:0]  wo [6]  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        logic [15:0] eo [5]  = '{16'h224, 16'h268, 16'h2AC, 16'h2F0, 16'h334};
        logic [7:0]  wr [3]  = '{8'h81, 8'h5A, 8'hC3};
        int          done_seen;
        int          act_seen;

        rst_n = 4'b0000;
        tx_dv = 4'b0000;
        b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        repeat (3) @(negedge clk);

        // Outputs while held in reset
        chk("rst_serial",   {28'h0, ser}, 32'hF);
        chk("rst_active",   {28'h0, act}, 32'h0);
        chk("rst_done",     {28'h0, dn},  32'h0);
        chk("rst_overflow", {28'h0, ovf}, 32'h0);
        chk("rst_count",    {29'h0, cnt0}, 32'h0);
        chk("rst_ready",    {28'h0, rdy}, 32'hF);
        rst_n = 4'b1111;
        repeat (2) @(negedge clk);
        chk("idle_serial", {28'h0, ser}, 32'hF);

        // Parity and two-stop-bit frames
        tx_dv[3:1] = 3'b111;
        b1 = 8'h07; exp_q[1].push_back(16'h60E);
        b2 = 8'h07; exp_q[2].push_back(16'h40E);
        b3 = 7'h41; exp_q[3].push_back(16'h382);
        @(negedge clk);
        tx_dv[3:1] = 3'b000;
        wait_idle(1, 200);
        wait_idle(2, 200);
        wait_idle(3, 200);

        // Single 8N1 frame and first-bit latency
        tx_dv[0] = 1'b1; b0 = 8'hA5; exp_q[0].push_back(16'h34A);
        @(negedge clk);
        tx_dv[0] = 1'b0;
        chk("latency_still_idle", {31'h0, ser[0]}, 32'h1);
        chk("count_after_push", {29'h0, cnt0}, 32'h1);
        @(negedge clk);
        chk("latency_start_low", {31'h0, ser[0]}, 32'h0);
        chk("latency_active", {31'h0, act[0]}, 32'h1);
        chk("count_after_pop", {29'h0, cnt0}, 32'h0);
        wait_idle(0, 200);
        chk("idle_after_frame", {30'h0, act[0], ser[0]}, 32'h1);

        // Three words back to back
        for (int i = 0; i < 3; i++) begin
            tx_dv[0] = 1'b1; b0 = w3[i]; exp_q[0].push_back(e3[i]);
            @(negedge clk);
        end
        tx_dv[0] = 1'b0;
        chk("count_peak_2", {29'h0, cnt0}, 32'h2);
        wait_idle(0, 400);
        chk("count_drained", {29'h0, cnt0}, 32'h0);

        // Overflow: six pushes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                chk("full_count", {29'h0, cnt0}, 32'h4);
                chk("full_not_ready", {31'h0, rdy[0]}, 32'h0);
                chk("no_overflow_yet", {31'h0, ovf[0]}, 32'h0);
            end
            tx_dv[0] = 1'b1; b0 = wo[i];
            if (i < 5) exp_q[0].push_back(eo[i]);
            @(negedge clk);
        end
        tx_dv[0] = 1'b0;
        chk("overflow_pulse", {31'h0, ovf[0]}, 32'h1);
        chk("count_after_drop", {29'h0, cnt0}, 32'h4);
        @(negedge clk);
        chk("overflow_one_cycle", {31'h0, ovf[0]}, 32'h0);
        wait_idle(0, 600);
        chk("ready_after_drain", {31'h0, rdy[0]}, 32'h1);

        // Reset in the middle of the data bits with two words queued
        for (int i = 0; i < 3; i++) begin
            tx_dv[0] = 1'b1; b0 = wr[i];
            @(negedge clk);
        end
        tx_dv[0] = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        exp_q[0].delete();
        #1;
        chk("midrst_serial", {31'h0, ser[0]}, 32'h1);
        chk("midrst_active", {31'h0, act[0]}, 32'h0);
        chk("midrst_count",  {29'h0, cnt0},   32'h0);
        chk("midrst_done",   {31'h0, dn[0]},  32'h0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        done_seen = 0;
        act_seen  = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (dn[0] !== 1'b0) done_seen++;
            if (act[0] !== 1'b0 || ser[0] !== 1'b1) act_seen++;
        end
        chk("post_rst_no_done", done_seen, 0);
        chk("post_rst_line_idle", act_seen, 0);
        chk("post_rst_count", {29'h0, cnt0}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
